// File: rtl/player_motion_unit_pkg.sv
// ============================================================================
// player_motion_unit_pkg : shared move encodings and FSM states
// Revision 1.0
// ============================================================================
`default_nettype none

package player_motion_unit_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_STEP  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } pmu_state_e;

endpackage

`default_nettype wire

// File: rtl/player_motion_unit_move_timer.sv
// ============================================================================
// move_timer : clearable pacing counter, one-cycle done at count TICKS-1
// Revision 1.0
// ============================================================================
`default_nettype none

module move_timer #(
  parameter int TICKS = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int            TW   = $clog2(TICKS + 1);
  localparam logic [TW-1:0] LAST = TW'(TICKS - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    done    = enable && (count_q == LAST);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = done ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/player_motion_unit.sv
// ============================================================================
// player_motion_unit : paced player-move datapath with obstacle check and win
// flag. Define PMU_WRAP_EN for wrap-around edges (default: clamp).
// Revision 1.0
// ============================================================================
`default_nettype none

module player_motion_unit
  import player_motion_unit_pkg::*;
#(
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int X_MAX  = 159,
  parameter int Y_MAX  = 119,
  parameter int INIT_X = 0,
  parameter int INIT_Y = 0,
  parameter int WIN_X  = 159,
  parameter int WIN_Y  = 119,
  parameter int STEP   = 1,
  parameter int TICKS  = 12500000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          move_valid,
  input  logic [2:0]    move_dir,
  output logic          move_ready,
  output logic [XW-1:0] query_x,
  output logic [YW-1:0] query_y,
  input  logic          obs_hit,
  output logic [XW-1:0] xpos,
  output logic [YW-1:0] ypos,
  output logic          plot,
  output logic          timer_done,
  output logic          did_win
);

  localparam logic [XW:0]   STEP_X = (XW+1)'(STEP);
  localparam logic [YW:0]   STEP_Y = (YW+1)'(STEP);
  localparam logic [XW:0]   LIM_X  = (XW+1)'(X_MAX);
  localparam logic [YW:0]   LIM_Y  = (YW+1)'(Y_MAX);
  localparam logic [XW-1:0] INIT_XV = XW'(INIT_X);
  localparam logic [YW-1:0] INIT_YV = YW'(INIT_Y);
  localparam logic [XW-1:0] WIN_XV  = XW'(WIN_X);
  localparam logic [YW-1:0] WIN_YV  = YW'(WIN_Y);
`ifdef PMU_WRAP_EN
  localparam logic [XW:0]   MOD_X  = (XW+1)'(X_MAX + 1);
  localparam logic [YW:0]   MOD_Y  = (YW+1)'(Y_MAX + 1);
`endif

  pmu_state_e    state_q, state_d;
  logic [2:0]    dir_q, dir_d;
  logic [XW-1:0] xpos_q, xpos_d, qx_q, qx_d, cand_x;
  logic [YW-1:0] ypos_q, ypos_d, qy_q, qy_d, cand_y;
  logic          did_win_q, did_win_d;
  logic          tmr_clear, tmr_en, tmr_done;
  logic [XW:0]   x_sum, x_fix;
  logic [YW:0]   y_sum, y_fix;
  logic          x_under, x_over, y_under, y_over;

  move_timer #(.TICKS(TICKS)) u_move_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .done   (tmr_done)
  );

  // One extra bit lets the MSB flag an underflow below zero.
  always_comb begin
    x_sum   = {1'b0, xpos_q};
    y_sum   = {1'b0, ypos_q};
    x_under = 1'b0;
    x_over  = 1'b0;
    y_under = 1'b0;
    y_over  = 1'b0;
    case (dir_q)
      DIR_UP:    begin y_sum = {1'b0, ypos_q} - STEP_Y; y_under = y_sum[YW];      end
      DIR_DOWN:  begin y_sum = {1'b0, ypos_q} + STEP_Y; y_over  = (y_sum > LIM_Y); end
      DIR_LEFT:  begin x_sum = {1'b0, xpos_q} - STEP_X; x_under = x_sum[XW];      end
      DIR_RIGHT: begin x_sum = {1'b0, xpos_q} + STEP_X; x_over  = (x_sum > LIM_X); end
      default:   ;
    endcase
    x_fix = x_sum;
    y_fix = y_sum;
`ifdef PMU_WRAP_EN
    if (x_under)     x_fix = x_sum + MOD_X;
    else if (x_over) x_fix = x_sum - MOD_X;
    if (y_under)     y_fix = y_sum + MOD_Y;
    else if (y_over) y_fix = y_sum - MOD_Y;
`else
    if (x_under)     x_fix = '0;
    else if (x_over) x_fix = LIM_X;
    if (y_under)     y_fix = '0;
    else if (y_over) y_fix = LIM_Y;
`endif
    cand_x = x_fix[XW-1:0];
    cand_y = y_fix[YW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    did_win_d  = did_win_q;
    move_ready = 1'b0;
    plot       = 1'b0;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        move_ready = 1'b1;
        if (move_valid && (move_dir >= DIR_UP) && (move_dir <= DIR_RIGHT)) begin
          dir_d     = move_dir;
          tmr_clear = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        tmr_en = 1'b1;
        if (tmr_done) state_d = S_STEP;
      end
      S_STEP: begin
        qx_d    = cand_x;
        qy_d    = cand_y;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (!obs_hit) begin
          plot   = 1'b1;
          xpos_d = qx_q;
          ypos_d = qy_q;
          if ((qx_q == WIN_XV) && (qy_q == WIN_YV)) begin
            did_win_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE:  ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_NONE;
      xpos_q    <= INIT_XV;
      ypos_q    <= INIT_YV;
      qx_q      <= INIT_XV;
      qy_q      <= INIT_YV;
      did_win_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      qx_q      <= qx_d;
      qy_q      <= qy_d;
      did_win_q <= did_win_d;
    end
  end

  assign xpos       = xpos_q;
  assign ypos       = ypos_q;
  assign query_x    = qx_q;
  assign query_y    = qy_q;
  assign did_win    = did_win_q;
  assign timer_done = tmr_done;

endmodule

`default_nettype wire

// File: tb/tb_player_motion_unit.sv
// ============================================================================
// tb_player_motion_unit : directed + random bench with a cycle-schedule model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_player_motion_unit;

  localparam int XW = 8, YW = 7, X_MAX = 159, Y_MAX = 119;
  localparam int WIN_X = 2, WIN_Y = 0, STEP = 1, TICKS = 4;
`ifdef PMU_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, move_valid, obs_hit;
  logic [2:0]    move_dir;
  logic          move_ready, plot, timer_done, did_win;
  logic [XW-1:0] query_x, xpos;
  logic [YW-1:0] query_y, ypos;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  player_motion_unit #(
    .XW(XW), .YW(YW), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .INIT_X(0), .INIT_Y(0),
    .WIN_X(WIN_X), .WIN_Y(WIN_Y), .STEP(STEP), .TICKS(TICKS)
  ) dut (
    .clk(clk), .reset(reset), .move_valid(move_valid), .move_dir(move_dir),
    .move_ready(move_ready), .query_x(query_x), .query_y(query_y), .obs_hit(obs_hit),
    .xpos(xpos), .ypos(ypos), .plot(plot), .timer_done(timer_done), .did_win(did_win)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: position, query register and the index of the current cycle
  // counted from the accepting handshake (-1 when no move is in flight).
  int mx, my, mqx, mqy, cx, cy, mk;
  bit mdone;

  function automatic int edge_fix(input int v, input int vmax);
    if (WRAP) return (v + vmax + 1) % (vmax + 1);
    if (v < 0) return 0;
    if (v > vmax) return vmax;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mx = 0; my = 0; mqx = 0; mqy = 0; mk = -1; mdone = 1'b0;
    end else if (mk >= 0) begin
      if (mk == TICKS + 1) begin mqx = cx; mqy = cy; end
      if (mk == TICKS + 2) begin
        if (!obs_hit) begin
          mx = mqx; my = mqy;
          if (mx == WIN_X && my == WIN_Y) mdone = 1'b1;
        end
        mk = -1;
      end else begin
        mk++;
      end
    end else if (!mdone && move_valid && int'(move_dir) >= 1 && int'(move_dir) <= 4) begin
      cx = mx; cy = my;
      case (int'(move_dir))
        1: cy = my - STEP;
        2: cy = my + STEP;
        3: cx = mx - STEP;
        default: cx = mx + STEP;
      endcase
      cx = edge_fix(cx, X_MAX);
      cy = edge_fix(cy, Y_MAX);
      mk = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (reset) begin
        chk("rst_xpos", 32'(xpos), 0);
        chk("rst_ypos", 32'(ypos), 0);
        chk("rst_query", {query_x, 8'h0, 9'h0, query_y}, 0);
        chk("rst_ready", 32'(move_ready), 1);
        chk("rst_plot_td_win", {plot, timer_done, did_win}, 0);
      end else begin
        chk("xpos", 32'(xpos), mx);
        chk("ypos", 32'(ypos), my);
        chk("query_x", 32'(query_x), mqx);
        chk("query_y", 32'(query_y), mqy);
        chk("did_win", 32'(did_win), 32'(mdone));
        chk("move_ready", 32'(move_ready), 32'(mk < 0 && !mdone));
        chk("timer_done", 32'(timer_done), 32'(mk == TICKS));
        chk("plot", 32'(plot), 32'(mk == TICKS + 2 && !obs_hit));
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; move_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Issue one command when ready; report cycle indices (relative to the
  // handshake) of the first timer_done, plot and move_ready, or -1.
  task automatic move(input int dir, input bit obs, output int td_at, output int pl_at, output int rd_at);
    int guard = 0;
    @(posedge clk); #1;
    while (!move_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    if (!move_ready) chk("ready_timeout", 0, 1);
    move_valid = 1'b1; move_dir = 3'(dir); obs_hit = obs;
    @(posedge clk); #1;
    move_valid = 1'b0; move_dir = 3'($urandom_range(0, 7));
    td_at = -1; pl_at = -1; rd_at = -1;
    for (int k = 1; k <= TICKS + 6; k++) begin
      @(negedge clk);
      if (timer_done && td_at < 0) td_at = k;
      if (plot && pl_at < 0) pl_at = k;
      if (move_ready && rd_at < 0) rd_at = k;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int td, pl, rd, n;
    reset = 1'b1; move_valid = 1'b0; move_dir = 3'd0; obs_hit = 1'b0;
    mk = -1; mdone = 1'b0; mx = 0; my = 0; mqx = 0; mqy = 0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: basic right move and latency
    move(4, 1'b0, td, pl, rd);
    chk("t1_td_cycle", td, TICKS);
    chk("t1_plot_cycle", pl, TICKS + 2);
    chk("t1_ready_cycle", rd, TICKS + 3);
    chk("t1_xpos", 32'(xpos), 1);

    // 2: blocked move from (5,5)
    apply_reset();
    repeat (5) move(2, 1'b0, td, pl, rd);
    repeat (5) move(4, 1'b0, td, pl, rd);
    move(1, 1'b1, td, pl, rd);
    chk("t2_no_plot", pl, -1);
    chk("t2_query", {16'(query_x), 16'(query_y)}, {16'd5, 16'd4});
    chk("t2_pos", {16'(xpos), 16'(ypos)}, {16'd5, 16'd5});

    // 3: left at x=0
    apply_reset();
    move(3, 1'b0, td, pl, rd);
    chk("t3_plot_cycle", pl, TICKS + 2);
    chk("t3_query_x", 32'(query_x), WRAP ? 159 : 0);
    chk("t3_xpos", 32'(xpos), WRAP ? 159 : 0);

    // 4: win at (2,0), then terminal
    apply_reset();
    move(4, 1'b0, td, pl, rd);
    chk("t4_first_no_win", 32'(did_win), 0);
    move(4, 1'b0, td, pl, rd);
    chk("t4_win", 32'(did_win), 1);
    chk("t4_ready_low", 32'(move_ready), 0);
    move_valid = 1'b1; move_dir = 3'd4; n = 0;
    repeat (TICKS + 6) begin @(negedge clk); if (plot) n++; end
    move_valid = 1'b0;
    chk("t4_done_no_plot", n, 0);
    chk("t4_win_sticky", {16'(did_win), 16'(xpos)}, {16'd1, 16'd2});

    // 5: reserved and none directions are dropped
    apply_reset();
    move(6, 1'b0, td, pl, rd);
    chk("t5_dir6", {td, pl, rd}, {-32'sd1, -32'sd1, 32'sd1});
    move(0, 1'b0, td, pl, rd);
    chk("t5_dir0", {td, pl, rd}, {-32'sd1, -32'sd1, 32'sd1});

    // 6: reset during WAIT, and move_valid held through a move
    apply_reset();
    @(posedge clk); #1 move_valid = 1'b1; move_dir = 3'd4;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1; move_valid = 1'b0;
    @(negedge clk);
    chk("t6_rst_ready", 32'(move_ready), 1);
    @(posedge clk); #1 reset = 1'b0;
    n = 0;
    repeat (8) begin @(negedge clk); if (timer_done) n++; end
    chk("t6_no_td", n, 0);
    chk("t6_pos", {16'(xpos), 16'(ypos)}, 0);
    @(posedge clk); #1 move_valid = 1'b1; move_dir = 3'd2;
    n = 0;
    repeat (2 * (TICKS + 3)) begin @(negedge clk); if (move_valid && move_ready) n++; end
    move_valid = 1'b0;
    chk("t6_held_handshakes", n, 2);

    // 7: bottom and right edges
    apply_reset();
    repeat (119) move(2, 1'b0, td, pl, rd);
    chk("t7_y_max", 32'(ypos), 119);
    move(2, 1'b0, td, pl, rd);
    chk("t7_y_edge", 32'(ypos), WRAP ? 0 : 119);
    chk("t7_y_edge_plot", pl, TICKS + 2);
    apply_reset();
    move(2, 1'b0, td, pl, rd);
    repeat (159) move(4, 1'b0, td, pl, rd);
    chk("t7_x_max", 32'(xpos), 159);
    move(4, 1'b0, td, pl, rd);
    chk("t7_x_edge", 32'(xpos), WRAP ? 0 : 159);

    // random traffic
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (did_win || $urandom_range(0, 399) == 0) begin
        reset = 1'b1; move_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
      end
      move_valid = ($urandom_range(0, 2) == 0);
      move_dir   = 3'($urandom_range(0, 7));
      obs_hit    = ($urandom_range(0, 3) == 0);
    end
    move_valid = 1'b0;
    @(negedge clk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
